sm_noc_router: RTL
==================

// Module: sm_noc_router
// PURPOSE
//  Parametrised N-port wormhole-free NoC router joining sm_cpu cores on a single-flit network.
//  Each input has a FIFO. Each output has a round-robin arbiter and a registered valid/ready stage.
//  Destination is carried in the flit MSBs.
//  Sits in sm_top between the core network interfaces, one port per core.
// PARAMETERS
//  N_PORTS     4    number of input/output port pairs (2..8)
//  DATA_W      128  flit width in bits; dest field = flit[DATA_W-1 -: DEST_W]
//  FIFO_DEPTH  4    input FIFO entries per port, power of two, >=2
//  DEST_W      derived localparam = max(1,$clog2(N_PORTS)), not overridable
// PORTS
//  clk        in   1               system clock, all logic on posedge
//  rst        in   1               synchronous reset, active-high
//  in_data    in   N_PORTS*DATA_W  input flits, port i at [i*DATA_W +: DATA_W]
//  in_valid   in   N_PORTS         input flit valid per port
//  in_ready   out  N_PORTS         input FIFO can accept per port
//  out_data   out  N_PORTS*DATA_W  output flits, port j at [j*DATA_W +: DATA_W]
//  out_valid  out  N_PORTS         output flit valid per port
//  out_ready  in   N_PORTS         downstream accepts per port
//  drop       out  N_PORTS         1-cycle pulse: input i discarded a flit with illegal dest
// BEHAVIOUR
//  Reset: FIFOs empty, out_valid=0, out_data=0, drop=0, all rr pointers=0.
//   in_ready=0 while rst=1. Reset mid-operation discards every buffered and output-stage flit.
//  Handshake: a transfer occurs on a posedge with valid&ready high.
//   Senders hold valid and data until accepted.
//   The router holds out_data[j] stable while out_valid[j]&!out_ready[j].
//  Input FIFO i: in_ready[i] = !rst & (count<FIFO_DEPTH), from registered count.
//   When full, no push occurs even if a pop happens the same cycle (no pass-through).
//   Push and pop in the same cycle when not full leaves count unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  Head decode: dest = head[DATA_W-1 -: DEST_W], valid only when FIFO i is non-empty.
//   dest>=N_PORTS: head popped that cycle, drop[i]=1 next cycle, nothing forwarded.
//  Output j load condition: load_j = !out_valid[j] | out_ready[j].
//   req_j = inputs with non-empty FIFO and head dest==j.
//   If load_j & |req_j: grant first set req bit searching upward from rr[j], wrapping.
//    Pop the granted FIFO. out_data[j] <= granted head, out_valid[j] <= 1, rr[j] <= (g+1)%N_PORTS.
//   If load_j & !req_j: out_valid[j] <= 0; out_data[j] holds its last value.
//   If !load_j: no grant, rr[j] unchanged.
//  Each head targets one output, so at most one pop per FIFO per cycle. No combinational in->out path.
//  Latency: flit accepted into an empty FIFO at edge T gives out_valid high after edge T+1 (2 cycles), if the output is free.
//  Throughput: 1 flit/cycle per output. Flits from input i to output j stay in order.
//  Fairness: under persistent contention, each requester is granted within N_PORTS grants.
// TESTING (N_PORTS=4, DATA_W=128, FIFO_DEPTH=4 unless noted)
//  Reset: hold rst=1 3 cycles -> in_ready=0, out_valid=0, out_data=0, drop=0.
//   First cycle after release -> in_ready=4'hF.
//  Single flit: in0 sends 128'h4000_..._00A5 (dest 1) at edge T, out_ready=4'hF.
//   -> out_valid=4'b0010 after T+1, port-1 data=4000_..._00A5, valid for 1 cycle.
//  Contention: inputs 0,2,3 send dest 3 at the same edge, out_ready[3]=1.
//   -> port 3 delivers in0, in2, in3 on consecutive cycles.
//   A repeat burst then delivers in0, in2, in3 again (rr wraps to 0).
//  Backpressure: out_ready[2]=0, in1 streams 6 flits (dest 2, payload 1..6).
//   -> 5 accepted, then in_ready[1]=0; out_data[2] holds payload 1 stable.
//   Raise out_ready -> payloads 1..6 in order, one per cycle.
//  Illegal dest: N_PORTS=3, in2 sends a flit with dest field 3.
//   -> drop=3'b100 for one cycle, out_valid stays 0, in_ready[2] stays 1.
//  Reset mid-operation: fill all FIFOs with out_ready=0, pulse rst for 1 cycle.
//   -> out_valid=0 and no stale flit ever appears after out_ready=4'hF.

Source files
------------

// File: rtl/sm_noc_router.sv
// sm_noc_router: N-port single-flit NoC router. Each input has a FIFO.
// Each output has a round-robin arbiter and a registered valid/ready stage.
// The destination port is carried in the flit MSBs.
module sm_noc_router #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS*DATA_W-1:0]   in_data,
  input  logic [N_PORTS-1:0]          in_valid,
  output logic [N_PORTS-1:0]          in_ready,
  output logic [N_PORTS*DATA_W-1:0]   out_data,
  output logic [N_PORTS-1:0]          out_valid,
  input  logic [N_PORTS-1:0]          out_ready,
  output logic [N_PORTS-1:0]          drop
);

  localparam int unsigned DEST_W = ($clog2(N_PORTS) > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [N_PORTS-1:0][DATA_W-1:0] w_in_flit;
  logic [N_PORTS-1:0][DATA_W-1:0] w_head;
  logic [N_PORTS-1:0][DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0]              r_mem [N_PORTS][FIFO_DEPTH];
  logic [N_PORTS-1:0][PTR_W-1:0]  r_wptr;
  logic [N_PORTS-1:0][PTR_W-1:0]  r_rptr;
  logic [N_PORTS-1:0][CNT_W-1:0]  r_count;
  logic [N_PORTS-1:0][DEST_W-1:0] w_dest;
  logic [N_PORTS-1:0][DEST_W-1:0] r_rr;
  logic [N_PORTS-1:0][DEST_W-1:0] w_gnt_idx;
  logic [N_PORTS-1:0][N_PORTS-1:0] w_req;  // [output][input]
  logic [N_PORTS-1:0]             w_nonempty;
  logic [N_PORTS-1:0]             w_illegal;
  logic [N_PORTS-1:0]             w_push;
  logic [N_PORTS-1:0]             w_pop;
  logic [N_PORTS-1:0]             w_load;
  logic [N_PORTS-1:0]             w_gnt_vld;
  logic [N_PORTS-1:0]             r_out_valid;
  logic [N_PORTS-1:0]             r_drop;

  assign w_in_flit = in_data;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign drop      = r_drop;

  // Head decode, illegal-destination detect and input acceptance from registered count
  always_comb begin
    w_head     = '0;
    w_nonempty = '0;
    w_dest     = '0;
    w_illegal  = '0;
    in_ready   = '0;
    w_push     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_head[i]     = r_mem[i][r_rptr[i]];
      w_nonempty[i] = (r_count[i] != '0);
      w_dest[i]     = w_head[i][DATA_W-1 -: DEST_W];
      w_illegal[i]  = w_nonempty[i] && (32'(w_dest[i]) >= N_PORTS);
      in_ready[i]   = !rst && (32'(r_count[i]) < FIFO_DEPTH);
      w_push[i]     = in_valid[i] && in_ready[i];
    end
  end

  // Per-output request build and round-robin grant; lowest offset from rr wins
  always_comb begin
    w_req     = '0;
    w_load    = '0;
    w_gnt_vld = '0;
    w_gnt_idx = '0;
    w_pop     = w_illegal;
    for (int j = 0; j < N_PORTS; j++) begin
      w_load[j] = !r_out_valid[j] || out_ready[j];
      for (int i = 0; i < N_PORTS; i++) begin
        w_req[j][i] = w_nonempty[i] && !w_illegal[i] && (w_dest[i] == DEST_W'(j));
      end
      if (w_load[j]) begin
        for (int k = N_PORTS - 1; k >= 0; k--) begin
          if (w_req[j][DEST_W'((32'(r_rr[j]) + 32'(k)) % N_PORTS)]) begin
            w_gnt_vld[j] = 1'b1;
            w_gnt_idx[j] = DEST_W'((32'(r_rr[j]) + 32'(k)) % N_PORTS);
          end
        end
      end
      if (w_gnt_vld[j]) begin
        w_pop[w_gnt_idx[j]] = 1'b1;
      end
    end
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
      end
    end
  end

  // Input FIFO storage; contents are only meaningful below the count
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= w_in_flit[i];
    end
  end

  // Output stages, rr pointers and drop pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_rr        <= '0;
      r_drop      <= '0;
    end else begin
      r_drop <= w_illegal;
      for (int j = 0; j < N_PORTS; j++) begin
        if (w_load[j]) begin
          if (w_gnt_vld[j]) begin
            r_out_data[j]  <= w_head[w_gnt_idx[j]];
            r_out_valid[j] <= 1'b1;
            r_rr[j]        <= DEST_W'((32'(w_gnt_idx[j]) + 32'd1) % N_PORTS);
          end else begin
            r_out_valid[j] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
